// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment bit positions,
// hex font (active-high, bit 0 = segment a) and pin-polarity helper.
package seg7_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Entry n holds the glyph for hex digit n, bits g..a.
  localparam logic [15:0][6:0] FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] apply_pol(input logic [7:0] bits, input logic active_low);
    return active_low ? ~bits : bits;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high a..g segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = FONT[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with guard time, leading-zero
// blanking and frame-synchronous display updates.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned GUARD          = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic                  pending,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = apply_pol(8'h00, SEG_ACTIVE_LOW);
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                pending_q, pending_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;

  logic                tick, last, boundary, in_guard, lit, zero_above;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank;
  logic [6:0]          font_seg;
  logic [7:0]          seg_bits;
  logic [DIGITS-1:0]   dig_hot;

  hex_to_seg7 u_font (
    .nibble (cur_nib),
    .seg7   (font_seg)
  );

  // Walk from the most significant digit down so zero_above covers nibbles i..DIGITS-1.
  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    zero_above = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_above = zero_above && (disp_val_q[4*(DIGITS-1-k) +: 4] == 4'h0);
      if (IDX_W'(DIGITS - 1 - k) == idx_q) begin
        cur_nib   = disp_val_q[4*(DIGITS-1-k) +: 4];
        cur_dp    = disp_dp_q[DIGITS-1-k];
        cur_blank = blank_lz && zero_above && (k != DIGITS - 1);
      end
    end
  end

  always_comb begin
    tick     = enable && (cnt_q == CNT_LAST);
    last     = (idx_q == IDX_LAST);
    boundary = !enable || (tick && last);

    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      idx_d = last ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // While disabled every cycle acts as a frame boundary, so loads land at once.
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pending_d  = pending_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
    end
    if (boundary) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pending_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end

    frame_done_d = tick && last;

    in_guard = (32'(cnt_q) < GUARD);
    lit      = enable && !in_guard;

    seg_bits              = '0;
    seg_bits[SEG_G:SEG_A] = cur_blank ? 7'h00 : font_seg;
    seg_bits[SEG_DP]      = cur_dp;
    dig_hot               = '0;
    dig_hot[idx_q]        = 1'b1;

    seg_d = lit ? apply_pol(seg_bits, SEG_ACTIVE_LOW) : SEG_OFF;
    dig_d = lit ? (DIG_ACTIVE_LOW ? ~dig_hot : dig_hot) : DIG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;
  assign seg        = seg_q;
  assign dig        = dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots, 1 guard cycle, active-low pins).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        pending, frame_done;
  logic [7:0]  seg;
  logic [3:0]  dig;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS         (4),
    .CLK_DIV        (4),
    .GUARD          (1),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .pending    (pending),
    .seg        (seg),
    .dig        (dig),
    .frame_done (frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  string font_s [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] font_of(input logic [3:0] n);
    string s;
    logic [6:0] r;
    r = '0;
    s = font_s[n];
    for (int j = 0; j < s.len(); j++) r[int'(s[j]) - 97] = 1'b1;
    return r;
  endfunction

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t        sb_q[$];
  logic [1:0]  m_cnt = '0, m_idx = '0;
  logic [15:0] m_disp = '0, m_pv = '0;
  logic [3:0]  m_dp = '0, m_pdp = '0;
  logic        m_pending = 1'b0;

  // Reference model: predicts post-edge outputs from pre-edge state and inputs.
  always @(posedge clk or negedge rst_n) begin : model
    exp_t       e;
    logic [7:0] litv;
    logic       bnd;
    if (!rst_n) begin
      m_cnt = '0; m_idx = '0; m_disp = '0; m_pv = '0;
      m_dp = '0; m_pdp = '0; m_pending = 1'b0;
      sb_q.delete();
    end else begin
      if (!enable || m_cnt < 2'd1) begin
        e.seg = 8'hFF;
        e.dig = 4'hF;
      end else begin
        litv = {m_dp[m_idx], font_of(m_disp[m_idx*4 +: 4])};
        if (blank_lz && m_idx != 2'd0 && (m_disp >> (4*m_idx)) == 16'h0) litv[6:0] = '0;
        e.seg = ~litv;
        e.dig = ~(4'b0001 << m_idx);
      end
      bnd  = !enable || (m_cnt == 2'd3 && m_idx == 2'd3);
      e.fd = enable && m_cnt == 2'd3 && m_idx == 2'd3;
      if (bnd) begin
        if (load) begin
          m_disp = value; m_dp = dp_in;
        end else if (m_pending) begin
          m_disp = m_pv; m_dp = m_pdp;
        end
        m_pending = 1'b0;
      end else if (load) begin
        m_pv = value; m_pdp = dp_in; m_pending = 1'b1;
      end
      if (!enable) begin
        m_cnt = '0; m_idx = '0;
      end else if (m_cnt == 2'd3) begin
        m_cnt = '0; m_idx = m_idx + 2'd1;
      end else begin
        m_cnt = m_cnt + 2'd1;
      end
      e.pend = m_pending;
      sb_q.push_back(e);
    end
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (!rst_n) begin
      check_eq("rst_seg", seg, 8'hFF);
      check_eq("rst_dig", dig, 4'hF);
    end else if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("sb_seg", seg, e.seg);
      check_eq("sb_dig", dig, e.dig);
      check_eq("sb_pending", pending, e.pend);
      check_eq("sb_frame_done", frame_done, e.fd);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < 200);
    check_eq("frame_done_seen", frame_done, 1'b1);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  logic [7:0] frame_seg [4] = '{8'h8E, 8'h88, 8'h24, 8'hF9};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] ed;
    cycles(3);
    check_eq("reset_seg", seg, 8'hFF);
    check_eq("reset_dig", dig, 4'hF);
    check_eq("reset_pending", pending, 1'b0);
    check_eq("reset_frame_done", frame_done, 1'b0);
    #2 rst_n = 1'b1;
    cycles(1);
    enable = 1'b1;

    // 12AF with dp on digit 2
    cycles(5);
    pulse_load(16'h12AF, 4'b0100);
    check_eq("pending_after_load", pending, 1'b1);
    wait_fd();
    check_eq("pending_cleared_at_fd", pending, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0) begin
        check_eq("frame_guard_dig", dig, 4'hF);
        check_eq("frame_guard_seg", seg, 8'hFF);
      end else begin
        ed = ~(4'b0001 << (k / 4));
        check_eq("frame_dig", dig, ed);
        check_eq("frame_seg", seg, frame_seg[k / 4]);
      end
    end

    // leading-zero blanking
    blank_lz = 1'b1;
    pulse_load(16'h0030, 4'b0000);
    wait_fd();
    cycles(14);
    check_eq("lz_digit3_seg", seg, 8'hFF);
    check_eq("lz_digit3_dig", dig, 4'b0111);
    cycles(2);
    pulse_load(16'h0000, 4'b0000);
    wait_fd();
    cycles(16);

    // last load wins, applied at the frame boundary
    cycles(5);
    pulse_load(16'h1111, 4'b0000);
    check_eq("pending_1111", pending, 1'b1);
    cycles(1);
    pulse_load(16'h2222, 4'b0000);
    wait_fd();
    check_eq("pending_clear_2222", pending, 1'b0);
    cycles(2);
    check_eq("shows_2_seg", seg, 8'hA4);
    check_eq("shows_2_dig", dig, 4'b1110);
    cycles(14);

    // load coincident with the last-digit tick
    cycles(15);
    pulse_load(16'h4321, 4'b0000);
    check_eq("tick_load_fd", frame_done, 1'b1);
    check_eq("tick_load_pending", pending, 1'b0);
    cycles(16);

    // enable low mid-scan
    cycles(6);
    enable = 1'b0;
    cycles(1);
    check_eq("dis_dig", dig, 4'hF);
    check_eq("dis_seg", seg, 8'hFF);
    cycles(2);
    pulse_load(16'h00C5, 4'b0000);
    check_eq("dis_load_pending", pending, 1'b0);
    cycles(6);
    enable = 1'b1;
    cycles(1);
    check_eq("reen_guard_dig", dig, 4'hF);
    cycles(1);
    check_eq("reen_dig0", dig, 4'b1110);
    check_eq("reen_seg5", seg, 8'h92);

    // asynchronous reset mid-slot discards a pending value
    pulse_load(16'h9999, 4'b1111);
    check_eq("pre_rst_pending", pending, 1'b1);
    cycles(1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_seg", seg, 8'hFF);
    check_eq("async_rst_dig", dig, 4'hF);
    check_eq("async_rst_pending", pending, 1'b0);
    cycles(2);
    #2 rst_n = 1'b1;
    cycles(1);
    check_eq("post_rst_pending", pending, 1'b0);
    wait_fd();
    cycles(2);
    check_eq("post_rst_seg0", seg, 8'hC0);
    check_eq("post_rst_dig0", dig, 4'b1110);
    cycles(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for DIGITS common-anode/cathode 7-segment digits plus decimal points.
- Successor to the 3-bit single-digit segment decoder: full hex (0-F) font, configurable digit count, scan rate and polarity, leading-zero blanking, anti-ghost guard time, and tear-free frame-synchronous value updates.
- Sits between datapath and board pins: datapath loads a packed value; block drives shared segment lines and one-hot digit enables.

Parameters:
- DIGITS, 4: number of digits scanned (1..8).
- CLK_DIV, 50000: clock cycles per digit slot (>= GUARD+2).
- GUARD, 16: cycles at the start of each slot with all digits off (0 = no guard, < CLK_DIV).
- SEG_ACTIVE_LOW, 1: 1 = segment lit when pin low.
- DIG_ACTIVE_LOW, 1: 1 = digit enabled when pin low.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scan enable; low = display dark
- load  in  1  one-cycle strobe: capture value/dp_in
- value  in  4*DIGITS  packed nibbles; nibble 0 (LSBs) = rightmost digit
- dp_in  in  DIGITS  decimal point per digit, bit i = digit i
- blank_lz  in  1  leading-zero blanking enable (sampled live)
- pending  out  1  captured value waiting for frame boundary
- seg  out  8  seg[0..6] = a..g, seg[7] = dp; polarity per SEG_ACTIVE_LOW
- dig  out  DIGITS  one-hot digit enable; polarity per DIG_ACTIVE_LOW
- frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (async, rst_n low): prescaler=0, idx=0, disp/pend regs=0, pending=0, frame_done=0, seg all inactive, dig all inactive. Release synchronous to clk.
- Prescaler counts 0..CLK_DIV-1 while enable=1; tick when count==CLK_DIV-1. On tick idx <= (idx==DIGITS-1) ? 0 : idx+1.
- seg/dig registered: they reflect the (idx, count) of the previous cycle; 1-cycle latency.
- Guard: when count < GUARD, dig all inactive and seg inactive. Otherwise dig[idx] active, all others inactive.
- Font, active-high before polarity:
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg
  - seg[7] = disp_dp[idx].
- Leading-zero blanking: when blank_lz=1, digit i is blanked (a..g off) if nibbles i..DIGITS-1 are all zero and i != 0. Digit 0 is never blanked. dp still follows disp_dp when blanked.
- Load/update:
  - load=1 captures value/dp_in into pend regs and sets pending=1. A later load before the boundary overwrites it (last wins).
  - At tick with idx==DIGITS-1: frame_done=1 next cycle. If pending or load, disp <= (load ? value : pend); pending <= 0.
  - Load coincident with that tick is applied directly; pending stays 0.
- enable=0: prescaler and idx held at 0; seg/dig inactive; frame_done=0. A load applies immediately next cycle (disp updated, pending stays 0).
- enable rising: scan restarts at digit 0, count 0, with guard applied.
- rst_n asserted mid-frame: immediate dark outputs, all state cleared; the pending value is lost.
- DIGITS=1: every tick is a frame boundary.

Decomposition:
- Package seg7_pkg:
  - segment index constants SEG_A..SEG_G, SEG_DP;
  - 16-entry 7-bit font constant;
  - function apply_pol(bits, active_low).
- Sub-module hex_to_seg7: combinational nibble -> 7-bit a..g active-high, using the package font.
- Top holds prescaler, idx, pend/disp registers, blanking logic, output registers.

Test Plan (DIGITS=4, CLK_DIV=4, GUARD=1, both polarities active-low):
- Reset, load value=16'h12AF, dp_in=4'b0100 -> pending=1 until frame_done. The following frame cycles:
  - dig 1110/seg F (aefg lit, dp off);
  - dig 1101/seg A;
  - dig 1011/seg 2 with dp low;
  - dig 0111/seg 1.
  - Each slot: 1 guard cycle with dig=1111, then 3 active cycles.
- blank_lz=1, value=16'h0030 -> digits 3,2 seg=8'hFF; digit 1 shows "3"; digit 0 shows "0". Value=16'h0000 -> only digit 0 lit, "0".
- Load 16'h1111 mid-frame, then 16'h2222 two cycles later -> the current frame keeps the old value; the next frame shows all "2"; pending cleared on the same cycle frame_done pulses.
- Load asserted exactly at the last-digit tick -> applied at that boundary, pending never rises.
- enable=0 for 10 cycles mid-scan -> dig=1111 and seg=8'hFF within 1 cycle. Load during this window updates disp immediately. Re-enable -> scan resumes at digit 0 after 1 guard cycle.
- rst_n pulsed low mid-slot (asynchronous, between edges) -> outputs inactive without waiting for a clock edge. After release, disp=0 and pending=0.
